// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences one shared ALU, the memory,
// the register file and the PC through fetch, decode, execute, memory and writeback.
module mips_mc_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               imm_zext,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_select,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_MEMADR = STATE_W'(3),
    S_MEMRD  = STATE_W'(4),
    S_MEMWB  = STATE_W'(5),
    S_MEMWR  = STATE_W'(6),
    S_REXEC  = STATE_W'(7),
    S_RWB    = STATE_W'(8),
    S_IEXEC  = STATE_W'(9),
    S_IWB    = STATE_W'(10),
    S_BRANCH = STATE_W'(11),
    S_JUMP   = STATE_W'(12)
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_OR  = 3'b010,
    ALU_NOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SUB = 3'b111
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Every control line is a flop, so the bundle is computed for the state being entered.
  typedef struct packed {
    logic       pc_write;
    logic       br_eq;
    logic       br_ne;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       imm_zext;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_select;
    logic [1:0] pc_src;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   mem_load_q, mem_load_d;
  logic   opcode_ok, funct_ok;

  always_comb begin
    unique case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: opcode_ok = 1'b1;
      default:                       opcode_ok = 1'b0;
    endcase
    unique case (funct)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND,
      FN_OR, FN_NOR, FN_SLT:         funct_ok = 1'b1;
      default:                       funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = S_FETCH;
    mem_load_d = mem_load_q;
    unique case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        mem_load_d = (opcode == OP_LW);
        unique case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_REXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = mem_load_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXEC:  state_d = funct_ok ? S_RWB : S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // IR is stable from the end of FETCH onward, so decoding opcode/funct one state early is safe.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH: begin
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.pc_write  = 1'b1;
      end
      S_DECODE: ctrl_d.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEMRD: ctrl_d.i_or_d = 1'b1;
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.i_or_d    = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_REXEC: begin
        ctrl_d.alu_src_a = 2'b01;
        unique case (funct)
          FN_ADD: ctrl_d.alu_select = ALU_ADD;
          FN_SUB: ctrl_d.alu_select = ALU_SUB;
          FN_AND: ctrl_d.alu_select = ALU_AND;
          FN_OR:  ctrl_d.alu_select = ALU_OR;
          FN_NOR: ctrl_d.alu_select = ALU_NOR;
          FN_SLT: ctrl_d.alu_select = ALU_SLT;
          FN_SLL, FN_SRL: begin
            // Shifts operate on rt, with shamt taken from the extended immediate.
            ctrl_d.alu_src_a  = 2'b10;
            ctrl_d.alu_src_b  = 2'b10;
            ctrl_d.alu_select = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
          end
          default: ctrl_d.alu_select = ALU_ADD;
        endcase
      end
      S_RWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.alu_select = ctrl_q.alu_select;
      end
      S_IEXEC: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b10;
        unique case (opcode)
          OP_ANDI: begin
            ctrl_d.alu_select = ALU_AND;
            ctrl_d.imm_zext   = 1'b1;
          end
          OP_ORI: begin
            ctrl_d.alu_select = ALU_OR;
            ctrl_d.imm_zext   = 1'b1;
          end
          OP_SLTI: ctrl_d.alu_select = ALU_SLT;
          default: ctrl_d.alu_select = ALU_ADD;
        endcase
      end
      S_IWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.imm_zext  = ctrl_q.imm_zext;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a  = 2'b01;
        ctrl_d.alu_select = ALU_SUB;
        ctrl_d.pc_src     = 2'b01;
        ctrl_d.br_eq      = (opcode == OP_BEQ);
        ctrl_d.br_ne      = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl_d.pc_src   = 2'b10;
        ctrl_d.pc_write = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      ctrl_q     <= '0;
      mem_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      mem_load_q <= mem_load_d;
    end
  end

  assign pc_en      = ctrl_q.pc_write | (ctrl_q.br_eq & zero) | (ctrl_q.br_ne & ~zero);
  assign ir_write   = ctrl_q.ir_write;
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign imm_zext   = ctrl_q.imm_zext;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_select = ctrl_q.alu_select;
  assign pc_src     = ctrl_q.pc_src;
  assign state_o    = state_q;

  // The illegal pulse is flagged in the cycle the offending field is decoded.
  assign illegal_op = ((state_q == S_DECODE) && !opcode_ok) ||
                      ((state_q == S_REXEC) && !funct_ok);

endmodule
